// File: rtl/iic_eeprom_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iic_eeprom_slave_pkg
// Brief    : Shared FSM states, bus event codes and page helpers
// Revision : 1.0
// ============================================================================
package iic_eeprom_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEV     = 4'd1,
        ST_DEV_ACK = 4'd2,
        ST_AHI     = 4'd3,
        ST_AHI_ACK = 4'd4,
        ST_ALO     = 4'd5,
        ST_ALO_ACK = 4'd6,
        ST_WDATA   = 4'd7,
        ST_WACK    = 4'd8,
        ST_RDATA   = 4'd9,
        ST_RACK    = 4'd10
    } iic_state_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_STOP  = 2'd2
    } bus_event_e;

    // PAGE_MASK = PAGE_SIZE - 1; PAGE_SIZE is a power of two
    function automatic int page_mask(input int page_size);
        return page_size - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iic_eeprom_slave_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : iic_bus_sync
// Brief    : SCL/SDA synchronizers with registered edge / START / STOP pulses
// Revision : 1.0
// ============================================================================
module iic_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [1:0] form the synchronizer, [2] is the previous synced value
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;
    logic       scl_rise_q, scl_rise_d;
    logic       scl_fall_q, scl_fall_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_in};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
        scl_rise_d = scl_pipe_q[1] & ~scl_pipe_q[2];
        scl_fall_d = ~scl_pipe_q[1] & scl_pipe_q[2];
        start_d    = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[1] & sda_pipe_q[2];
        stop_d     = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[1] & ~sda_pipe_q[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // delayed tap lines up with the registered pulses
    assign sda       = sda_pipe_q[2];
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule
`default_nettype wire

// File: rtl/iic_eeprom_slave.sv
`default_nettype none
// ============================================================================
// Module   : iic_eeprom_slave
// Brief    : I2C target emulating a 24Cxx EEPROM against an external byte memory
// Revision : 1.0
// ============================================================================
module iic_eeprom_slave
    import iic_eeprom_slave_pkg::*;
#(
    parameter int         SYS_CLK_FRE   = 50,
    parameter logic [6:0] DEV_ADDR      = 7'b1010000,
    parameter int         REG_ADDR_SIZE = 2,
    parameter int         MEM_ADDR_W    = 12,
    parameter int         PAGE_SIZE     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iic_scl,
    input  logic                  iic_sda_in,
    output logic                  iic_sda_out,
    output logic                  iic_sda_out_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    localparam logic [MEM_ADDR_W-1:0] PAGE_MASK = MEM_ADDR_W'(page_mask(PAGE_SIZE));

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    bus_event_e bus_ev;
    logic [15:0] word_addr;

    iic_state_e            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic                  rw_q, rw_d;
    logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
    logic                  sda_en_q, sda_en_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  busy_q, busy_d;

    iic_bus_sync u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (iic_scl),
        .sda_in    (iic_sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always_comb begin
        bus_ev = EV_NONE;
        if (stop_det) begin
            bus_ev = EV_STOP;
        end else if (start_det) begin
            bus_ev = EV_START;
        end
    end

    assign word_addr = (REG_ADDR_SIZE == 2) ? {addr_hi_q, shift_q} : {8'h00, shift_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_hi_d   = addr_hi_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_en_d    = sda_en_q;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        rd_pend_d   = mem_rd_q;
        busy_d      = busy_q;

        // write pointer advances the cycle after the strobe, wrapping inside the page
        if (mem_wr_q) begin
            ptr_d = (ptr_q & ~PAGE_MASK) | ((ptr_q + MEM_ADDR_W'(1)) & PAGE_MASK);
        end
        if (rd_pend_q) begin
            shift_d = mem_rdata;
        end

        case (bus_ev)
            EV_STOP: begin
                state_d   = ST_IDLE;
                sda_en_d  = 1'b0;
                bit_cnt_d = 4'd0;
                busy_d    = 1'b0;
            end
            EV_START: begin
                state_d   = ST_DEV;
                sda_en_d  = 1'b0;
                bit_cnt_d = 4'd0;
            end
            default: begin
                case (state_q)
                    ST_DEV, ST_AHI, ST_ALO, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_d   = {shift_q[6:0], sda_s};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
                                mem_wr_d    = 1'b1;
                                mem_wdata_d = {shift_q[6:0], sda_s};
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_d = 4'd0;
                            sda_en_d  = 1'b1;
                            case (state_q)
                                ST_DEV: begin
                                    if (shift_q[7:1] == DEV_ADDR) begin
                                        state_d = ST_DEV_ACK;
                                        rw_d    = shift_q[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d  = ST_IDLE;
                                        sda_en_d = 1'b0;
                                        busy_d   = 1'b0;
                                    end
                                end
                                ST_AHI: begin
                                    addr_hi_d = shift_q;
                                    state_d   = ST_AHI_ACK;
                                end
                                ST_ALO: begin
                                    ptr_d   = MEM_ADDR_W'(word_addr);
                                    state_d = ST_ALO_ACK;
                                end
                                default: state_d = ST_WACK;
                            endcase
                        end
                    end
                    ST_DEV_ACK, ST_AHI_ACK, ST_ALO_ACK, ST_WACK: begin
                        // bit_cnt=1 marks that the ACK clock has been seen high
                        if (scl_rise) begin
                            bit_cnt_d = 4'd1;
                            if (state_q == ST_DEV_ACK && rw_q) begin
                                mem_rd_d = 1'b1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            bit_cnt_d = 4'd0;
                            sda_en_d  = 1'b0;
                            case (state_q)
                                ST_DEV_ACK: begin
                                    if (rw_q) begin
                                        state_d  = ST_RDATA;
                                        sda_en_d = ~shift_q[7];
                                    end else if (REG_ADDR_SIZE == 2) begin
                                        state_d = ST_AHI;
                                    end else begin
                                        state_d = ST_ALO;
                                    end
                                end
                                ST_AHI_ACK: state_d = ST_ALO;
                                default:    state_d = ST_WDATA;
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q != 4'd0) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_d   = ST_RACK;
                                sda_en_d  = 1'b0;
                                bit_cnt_d = 4'd0;
                            end else begin
                                shift_d  = {shift_q[6:0], 1'b0};
                                sda_en_d = ~shift_q[6];
                            end
                        end
                    end
                    ST_RACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_d   = ST_IDLE;
                                busy_d    = 1'b0;
                                bit_cnt_d = 4'd0;
                            end else begin
                                bit_cnt_d = 4'd1;
                                ptr_d     = ptr_q + MEM_ADDR_W'(1);
                                mem_rd_d  = 1'b1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            state_d   = ST_RDATA;
                            bit_cnt_d = 4'd0;
                            sda_en_d  = ~shift_q[7];
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            addr_hi_q   <= 8'h00;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            mem_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_hi_q   <= addr_hi_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_en_q    <= sda_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            rd_pend_q   <= rd_pend_d;
            busy_q      <= busy_d;
        end
    end

    assign iic_sda_out    = 1'b0;
    assign iic_sda_out_en = sda_en_q;
    assign mem_addr       = ptr_q;
    assign mem_wr         = mem_wr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_rd         = mem_rd_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire
